// File: rtl/spi_nor_responder.sv
// spi_nor_responder
//   SPI NOR flash slave (mode 0) backed by an internal byte memory. It is the
//   far-end partner of the APB-to-SPI NOR controller. All SPI pins are
//   oversampled on p_clk, so p_clk must run at least 4x faster than s_clk.
//   Supported opcodes: WREN 06, WRDI 04, RDSR 05, RDID 9F, READ 03, PP 02.
//
// Ports
//   p_clk        in   system clock
//   p_rst        in   synchronous active-high reset (memory is not cleared)
//   s_clk        in   SPI clock from master
//   s_css        in   chip select, active low
//   s_mosi       in   master-out serial data, sampled on s_clk rise
//   s_miso       out  slave-out serial data, updated on s_clk fall, 0 when idle
//   wel          out  write-enable latch
//   wr_strobe    out  one-cycle pulse per byte written to memory
//   frame_active out  high while a selected frame is in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | deselected, waiting for s_css fall
// ST_CMD    | shifting in the opcode byte
// ST_ADDR   | shifting in the 3 address bytes (READ or PP)
// ST_STAT   | returning the status register on every byte
// ST_ID     | returning JEDEC ID bytes, then zeros
// ST_RDATA  | returning memory bytes, address wraps over the whole array
// ST_PROG   | writing received bytes, address wraps within the page
// ST_IGNORE | consuming clocks until deselect, s_miso held at 0

module spi_nor_responder #(
    parameter int          MEM_AW   = 8,
    parameter int          PAGE_AW  = 4,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic p_clk,
    input  logic p_rst,
    input  logic s_clk,
    input  logic s_css,
    input  logic s_mosi,
    output logic s_miso,
    output logic wel,
    output logic wr_strobe,
    output logic frame_active
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_STAT, ST_ID, ST_RDATA, ST_PROG, ST_IGNORE
    } state_t;

    localparam logic [MEM_AW-1:0] PAGE_MASK = MEM_AW'((32'd1 << PAGE_AW) - 32'd1);

    logic sclk_meta, sclk_sync, sclk_prev;
    logic css_meta, css_sync, css_prev;
    logic mosi_meta, mosi_sync;

    state_t            state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [6:0]        shift_in, shift_in_nxt;
    logic [7:0]        tx_sh, tx_sh_nxt;
    logic [MEM_AW-1:0] addr, addr_nxt;
    logic              is_read, is_read_nxt;
    logic              is_pp, is_pp_nxt;
    logic              wel_nxt, miso_nxt, wr_strobe_nxt, mem_we;

    // Stored inverted so that power-on-zero storage reads back as erased (8'hFF).
    logic [7:0]        mem_n [0:(1<<MEM_AW)-1];

    // Synchronizers are deliberately not reset: after a mid-frame reset the
    // edge history stays valid, so a still-low s_css does not look like a new
    // frame start.
    always_ff @(posedge p_clk) begin
        sclk_meta <= s_clk;
        sclk_sync <= sclk_meta;
        sclk_prev <= sclk_sync;
        css_meta  <= s_css;
        css_sync  <= css_meta;
        css_prev  <= css_sync;
        mosi_meta <= s_mosi;
        mosi_sync <= mosi_meta;
    end

    logic rise_p, fall_p, css_fall, css_rise, byte_done;
    logic [7:0]        rx_byte, rd_first, rd_next;
    logic [MEM_AW-1:0] addr_shift, addr_inc, addr_page_inc;

    assign rise_p    = sclk_sync & ~sclk_prev;
    assign fall_p    = ~sclk_sync & sclk_prev;
    assign css_fall  = css_prev & ~css_sync;
    assign css_rise  = ~css_prev & css_sync;
    assign rx_byte   = {shift_in, mosi_sync};
    assign byte_done = (state != ST_IDLE) && rise_p && (bit_cnt == 3'd7);

    // Address bytes are shifted through an MEM_AW-wide register; after three
    // bytes only the low MEM_AW bits of the wire address remain.
    assign addr_shift    = MEM_AW'({addr, rx_byte});
    assign addr_inc      = addr + 1'b1;
    assign addr_page_inc = (addr & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
    assign rd_first      = ~mem_n[addr_shift];
    assign rd_next       = ~mem_n[addr_inc];

    assign frame_active = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        byte_cnt_nxt  = byte_cnt;
        shift_in_nxt  = shift_in;
        tx_sh_nxt     = tx_sh;
        addr_nxt      = addr;
        is_read_nxt   = is_read;
        is_pp_nxt     = is_pp;
        wel_nxt       = wel;
        miso_nxt      = s_miso;
        wr_strobe_nxt = 1'b0;
        mem_we        = 1'b0;

        if (state == ST_IDLE) begin
            if (css_fall) begin
                state_nxt    = ST_CMD;
                bit_cnt_nxt  = 3'd0;
                byte_cnt_nxt = 2'd0;
                tx_sh_nxt    = 8'h00;
                addr_nxt     = '0;
                is_read_nxt  = 1'b0;
                is_pp_nxt    = 1'b0;
                miso_nxt     = 1'b0;
            end
        end else begin
            if (fall_p) begin
                miso_nxt  = tx_sh[7];
                tx_sh_nxt = {tx_sh[6:0], 1'b0};
            end
            if (rise_p) begin
                shift_in_nxt = rx_byte[6:0];
                bit_cnt_nxt  = bit_cnt + 3'd1;
            end
            if (byte_done) begin
                tx_sh_nxt = 8'h00;
                case (state)
                    ST_CMD: begin
                        state_nxt = ST_IGNORE;
                        case (rx_byte)
                            8'h06: wel_nxt = 1'b1;
                            8'h04: wel_nxt = 1'b0;
                            8'h05: begin
                                state_nxt = ST_STAT;
                                tx_sh_nxt = {6'b0, wel, 1'b0};
                            end
                            8'h9F: begin
                                state_nxt    = ST_ID;
                                tx_sh_nxt    = JEDEC_ID[23:16];
                                byte_cnt_nxt = 2'd1;
                            end
                            8'h03: begin
                                state_nxt   = ST_ADDR;
                                is_read_nxt = 1'b1;
                            end
                            8'h02: begin
                                is_pp_nxt = 1'b1;
                                if (wel) state_nxt = ST_ADDR;
                            end
                            default: state_nxt = ST_IGNORE;
                        endcase
                    end
                    ST_ADDR: begin
                        addr_nxt     = addr_shift;
                        byte_cnt_nxt = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) begin
                            if (is_read) begin
                                state_nxt = ST_RDATA;
                                tx_sh_nxt = rd_first;
                            end else begin
                                state_nxt = ST_PROG;
                            end
                        end
                    end
                    ST_STAT: tx_sh_nxt = {6'b0, wel, 1'b0};
                    ST_ID: begin
                        case (byte_cnt)
                            2'd1: tx_sh_nxt = JEDEC_ID[15:8];
                            2'd2: tx_sh_nxt = JEDEC_ID[7:0];
                            default: tx_sh_nxt = 8'h00;
                        endcase
                        if (byte_cnt != 2'd3) byte_cnt_nxt = byte_cnt + 2'd1;
                    end
                    ST_RDATA: begin
                        addr_nxt  = addr_inc;
                        tx_sh_nxt = rd_next;
                    end
                    ST_PROG: begin
                        mem_we        = 1'b1;
                        wr_strobe_nxt = 1'b1;
                        addr_nxt      = addr_page_inc;
                    end
                    default: tx_sh_nxt = 8'h00;
                endcase
            end
            // A byte finishing in the same cycle as deselect still counts.
            if (css_rise) begin
                state_nxt   = ST_IDLE;
                bit_cnt_nxt = 3'd0;
                miso_nxt    = 1'b0;
                if (is_pp_nxt) wel_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            shift_in  <= 7'd0;
            tx_sh     <= 8'h00;
            addr      <= '0;
            is_read   <= 1'b0;
            is_pp     <= 1'b0;
            wel       <= 1'b0;
            s_miso    <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            byte_cnt  <= byte_cnt_nxt;
            shift_in  <= shift_in_nxt;
            tx_sh     <= tx_sh_nxt;
            addr      <= addr_nxt;
            is_read   <= is_read_nxt;
            is_pp     <= is_pp_nxt;
            wel       <= wel_nxt;
            s_miso    <= miso_nxt;
            wr_strobe <= wr_strobe_nxt;
        end
    end

    always_ff @(posedge p_clk) begin
        if (mem_we && !p_rst) mem_n[addr] <= ~rx_byte;
    end

endmodule

// File: tb/tb_spi_nor_responder.sv
module tb_spi_nor_responder;

    localparam int HALF = 40;

    logic p_clk = 1'b0;
    logic p_rst = 1'b1;
    logic s_clk = 1'b0;
    logic s_css = 1'b1;
    logic s_mosi = 1'b0;
    logic s_miso, wel, wr_strobe, frame_active;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int hi_cyc = 0;

    logic [7:0] mdl_mem [256];
    logic       mdl_wel;
    logic [7:0] tx_buf  [32];
    logic [7:0] rx_buf  [32];
    logic [7:0] exp_buf [32];
    int         tx_len;
    int         exp_wr;

    spi_nor_responder #(.MEM_AW(8), .PAGE_AW(4), .JEDEC_ID(24'hEF4016)) dut (
        .p_clk(p_clk), .p_rst(p_rst), .s_clk(s_clk), .s_css(s_css), .s_mosi(s_mosi),
        .s_miso(s_miso), .wel(wel), .wr_strobe(wr_strobe), .frame_active(frame_active)
    );

    always #5 p_clk = ~p_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare: once the bench has held s_css high for a few cycles
    // the slave must be fully quiet.
    always @(negedge p_clk) begin
        if (wr_strobe) wr_cnt++;
        hi_cyc = s_css ? hi_cyc + 1 : 0;
        if (hi_cyc > 5)
            check("idle_quiet", {29'd0, frame_active, s_miso, wr_strobe}, 32'd0);
    end

    // Frame-level model: what the master must see on s_miso for each byte,
    // how many bytes get written, and the resulting memory/WEL.
    task automatic model_frame();
        logic [7:0] a, page, off;
        exp_wr = 0;
        for (int i = 0; i < tx_len; i++) exp_buf[i] = 8'h00;
        case (tx_buf[0])
            8'h06: mdl_wel = 1'b1;
            8'h04: mdl_wel = 1'b0;
            8'h05: for (int i = 1; i < tx_len; i++) exp_buf[i] = mdl_wel ? 8'h02 : 8'h00;
            8'h9F: for (int i = 1; i < tx_len; i++)
                       exp_buf[i] = (i == 1) ? 8'hEF : (i == 2) ? 8'h40 : (i == 3) ? 8'h16 : 8'h00;
            8'h03: begin
                a = tx_buf[3];
                for (int i = 4; i < tx_len; i++) exp_buf[i] = mdl_mem[(a + i - 4) % 256];
            end
            8'h02: begin
                if (mdl_wel) begin
                    page = tx_buf[3] & 8'hF0;
                    off  = tx_buf[3] & 8'h0F;
                    for (int i = 4; i < tx_len; i++) begin
                        mdl_mem[page | ((off + i - 4) % 16)] = tx_buf[i];
                        exp_wr++;
                    end
                end
                mdl_wel = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            s_mosi = b[i];
            #HALF;
            r[i] = s_miso;
            s_clk = 1'b1;
            #HALF;
            s_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input string name);
        logic [7:0] r;
        int w0;
        model_frame();
        w0 = wr_cnt;
        s_css = 1'b0;
        #(2*HALF);
        check({name, "_active"}, {31'd0, frame_active}, 32'd1);
        for (int i = 0; i < tx_len; i++) begin
            spi_bits(tx_buf[i], 8, r);
            rx_buf[i] = r;
            check($sformatf("%s_byte%0d", name, i), {24'd0, r}, {24'd0, exp_buf[i]});
        end
        #HALF;
        s_css = 1'b1;
        #(3*HALF);
        check({name, "_end_active"}, {31'd0, frame_active}, 32'd0);
        check({name, "_wel"}, {31'd0, wel}, {31'd0, mdl_wel});
        check({name, "_wr_count"}, wr_cnt - w0, exp_wr);
    endtask

    task automatic set1(input logic [7:0] b0);
        tx_buf[0] = b0; tx_len = 1;
    endtask
    task automatic set2(input logic [7:0] b0, input logic [7:0] b1);
        tx_buf[0] = b0; tx_buf[1] = b1; tx_len = 2;
    endtask
    task automatic set_addr(input logic [7:0] op, input logic [7:0] a, input int extra);
        tx_buf[0] = op; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = a;
        for (int i = 0; i < extra; i++) tx_buf[4 + i] = 8'h00;
        tx_len = 4 + extra;
    endtask

    initial begin
        #5ms;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] r;
        int w0;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'hFF;
        mdl_wel = 1'b0;

        repeat (5) @(negedge p_clk);
        check("rst_miso", {31'd0, s_miso}, 32'd0);
        check("rst_wel", {31'd0, wel}, 32'd0);
        check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_active", {31'd0, frame_active}, 32'd0);
        p_rst = 1'b0;
        repeat (10) @(negedge p_clk);

        // RDID
        set_addr(8'h9F, 8'h00, 1);
        run_frame("rdid");
        check("rdid_lit0", {24'd0, rx_buf[1]}, 32'hEF);
        check("rdid_lit1", {24'd0, rx_buf[2]}, 32'h40);
        check("rdid_lit2", {24'd0, rx_buf[3]}, 32'h16);
        check("rdid_lit3", {24'd0, rx_buf[4]}, 32'h00);

        // PP without WREN has no effect
        set_addr(8'h02, 8'h10, 1); tx_buf[4] = 8'hAA;
        run_frame("pp_nowel");
        set_addr(8'h03, 8'h10, 1);
        run_frame("rd10");
        check("rd10_lit", {24'd0, rx_buf[4]}, 32'hFF);

        // WREN, status, page-wrapping program
        set1(8'h06); run_frame("wren");
        set2(8'h05, 8'h00); run_frame("rdsr1");
        check("rdsr1_lit", {24'd0, rx_buf[1]}, 32'h02);
        set_addr(8'h02, 8'h1E, 3); tx_buf[4] = 8'h11; tx_buf[5] = 8'h22; tx_buf[6] = 8'h33;
        run_frame("pp3");
        set2(8'h05, 8'h00); run_frame("rdsr2");
        check("rdsr2_lit", {24'd0, rx_buf[1]}, 32'h00);
        set_addr(8'h03, 8'h1E, 2); run_frame("rd1e");
        check("rd1e_lit", {24'd0, rx_buf[4]}, 32'h11);
        check("rd1f_lit", {24'd0, rx_buf[5]}, 32'h22);
        set_addr(8'h03, 8'h10, 1); run_frame("rd10b");
        check("rd10b_lit", {24'd0, rx_buf[4]}, 32'h33);

        // Array wrap on READ
        set1(8'h06); run_frame("wren2");
        set_addr(8'h02, 8'h00, 1); tx_buf[4] = 8'h5A; run_frame("pp00");
        set1(8'h06); run_frame("wren3");
        set_addr(8'h02, 8'hFF, 1); tx_buf[4] = 8'hC3; run_frame("ppff");
        set_addr(8'h03, 8'hFF, 2); run_frame("rdwrap");
        check("rdwrap_ff", {24'd0, rx_buf[4]}, 32'hC3);
        check("rdwrap_00", {24'd0, rx_buf[5]}, 32'h5A);

        // Abort mid data byte
        set1(8'h06); run_frame("wren4");
        w0 = wr_cnt;
        s_css = 1'b0;
        #(2*HALF);
        spi_bits(8'h02, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h40, 8, r);
        spi_bits(8'h77, 5, r);
        #HALF;
        s_css = 1'b1;
        #(3*HALF);
        mdl_wel = 1'b0;
        check("abort_wr", wr_cnt - w0, 0);
        check("abort_wel", {31'd0, wel}, 32'd0);
        set_addr(8'h03, 8'h40, 1); run_frame("rd40");
        check("rd40_lit", {24'd0, rx_buf[4]}, 32'hFF);

        // Reset in the middle of a READ
        set1(8'h06); run_frame("wren5");
        s_css = 1'b0;
        #(2*HALF);
        spi_bits(8'h03, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h1E, 8, r);
        spi_bits(8'h00, 8, r);
        spi_bits(8'h00, 4, r);
        @(negedge p_clk); p_rst = 1'b1;
        @(negedge p_clk); p_rst = 1'b0;
        @(negedge p_clk);
        mdl_wel = 1'b0;
        check("rst_mid_miso", {31'd0, s_miso}, 32'd0);
        check("rst_mid_active", {31'd0, frame_active}, 32'd0);
        check("rst_mid_wel", {31'd0, wel}, 32'd0);
        spi_bits(8'hFF, 8, r);
        check("rst_mid_quiet", {24'd0, r}, 32'h00);
        #HALF;
        s_css = 1'b1;
        #(3*HALF);
        set_addr(8'h9F, 8'h00, 0); run_frame("rdid2");
        check("rdid2_lit", {24'd0, rx_buf[1]}, 32'hEF);
        set_addr(8'h03, 8'h1E, 1); run_frame("rd1e_after");
        check("rd1e_after_lit", {24'd0, rx_buf[4]}, 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_nor_responder.md
Name: spi_nor_responder

Overview:
- SPI-side counterpart of the APB-to-SPI NOR flash controller: a synthesizable SPI NOR flash slave that answers the controller's command/address/data frames from an internal byte memory.
- Used as the far-end model in system benches and as an FPGA loopback target.
- Runs entirely on the system clock; oversamples s_clk/s_css/s_mosi.
- SPI mode 0: slave samples s_mosi on s_clk rise and drives s_miso on s_clk fall.

Parameters:
- MEM_AW, 8, memory address bits (2^MEM_AW bytes); wire address low MEM_AW bits used, upper bits ignored
- PAGE_AW, 4, page-program page size = 2^PAGE_AW bytes; must be <= MEM_AW
- JEDEC_ID, 24'hEF4016, 3-byte ID returned by RDID, MSB byte first

Ports:
- p_clk  in  1  system clock; must be >= 4x s_clk frequency
- p_rst  in  1  synchronous active-high reset
- s_clk  in  1  SPI clock from master
- s_css  in  1  chip select, active low
- s_mosi  in  1  master-out serial data
- s_miso  out  1  slave-out serial data
- wel  out  1  write-enable-latch status
- wr_strobe  out  1  one-cycle pulse per byte committed to memory
- frame_active  out  1  high while a selected frame is in progress

Behaviour:
- Input sync: s_clk, s_css, s_mosi each pass through 2 flops.
- Edge detect on synced s_clk gives rise_p/fall_p; all logic uses synced copies only.
- Reset (p_rst=1 at p_clk edge):
  - state=IDLE, s_miso=0, wel=0, wr_strobe=0, frame_active=0, bit/byte counters=0.
  - Memory contents are NOT cleared; they are initialised to 8'hFF at time 0 only.
  - Reset mid-frame aborts the frame; no write commits after reset until the next s_css fall.
- Frame start: synced s_css 1->0 sets state=CMD, frame_active=1, bit counter=0. An s_clk rise seen in the same cycle as the s_css fall is ignored.
- Frame end: synced s_css 0->1 in any state:
  - state=IDLE, frame_active=0, s_miso=0; partial byte discarded.
  - If the frame opcode was PP and wel=1, wel clears on this cycle.
- Shift-in: on rise_p while selected, shift s_mosi in MSB first; bit counter 0..7 wraps. Byte complete on the 8th rise.
- Shift-out: on fall_p while selected, s_miso <= next MSB-first bit of tx byte.
  - tx byte is loaded when the previous byte completes, so its MSB appears on the first fall after that byte's 8th rise.
- States:
  - IDLE: wait for s_css fall.
  - CMD: on byte complete, decode opcode:
    - 0x06 WREN: wel=1 at completion -> IGNORE.
    - 0x04 WRDI: wel=0 -> IGNORE.
    - 0x05 RDSR -> STAT; tx byte = {6'b0, wel, 1'b0}, repeated for every further byte.
    - 0x9F RDID -> ID; tx JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 forever.
    - 0x03 READ -> ADDR (read).
    - 0x02 PP -> ADDR (prog) if wel=1, else IGNORE.
    - any other opcode -> IGNORE.
  - ADDR: collect 3 bytes, MSB first; addr = low MEM_AW bits.
    - After the 3rd byte: READ goes to RDATA and loads tx=mem[addr]; PP goes to PROG.
  - RDATA: at each byte complete, addr=addr+1 mod 2^MEM_AW and tx=mem[addr]. Reads continue indefinitely with full-array wrap.
  - PROG: at each byte complete:
    - mem[addr] <= rx byte, wr_strobe=1 for one cycle.
    - Low PAGE_AW bits of addr increment with wrap; upper bits are fixed (page wrap).
  - IGNORE: consume clocks; s_miso=0 until frame end.
- s_miso is 0 during CMD and ADDR and whenever deselected (no tristate).
- Memory write is synchronous; a read of the same address on the next byte returns new data.
- Simultaneous byte-complete and s_css rise in the same p_clk cycle: the byte counts as complete (commit/decode first), then frame ends.

Test Plan:
- RDID: css low, send 0x9F then 24 clocks -> s_miso bytes 0xEF,0x40,0x16; 8 more clocks -> 0x00.
- PP without WREN: 0x02,00,00,10,0xAA -> no wr_strobe. Then READ 0x03,00,00,10 + 8 clocks -> 0xFF.
- WREN frame; RDSR -> 0x02. PP 0x02,00,00,1E,0x11,0x22,0x33 -> wr_strobe x3; mem[0x1E]=0x11, mem[0x1F]=0x22, mem[0x10]=0x33 (page wrap). RDSR afterwards -> 0x00.
- READ 0x03,00,00,FF + 16 clocks -> mem[0xFF] then mem[0x00] (array wrap).
- Abort: WREN; PP 0x02,00,00,40 + 5 bits of a byte, then css high -> no wr_strobe, mem[0x40] unchanged, wel=0.
- Reset mid-READ after 12 data bits: p_rst 1 cycle -> s_miso=0, frame_active=0, wel=0. Next frame RDID still returns 0xEF; memory keeps earlier writes.
